// File: rtl/seg_led_pkg.sv
// seg_led_pkg: shared states, constants and hex decoder for the 74HC595 hex display driver
package seg_led_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_HOLD} state_t;
    typedef enum logic [1:0] {SER_IDLE, SER_SHIFT, SER_LATCH} ser_state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int SEL_W = 8;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'h3F;
            4'h1: hex_to_seg = 7'h06;
            4'h2: hex_to_seg = 7'h5B;
            4'h3: hex_to_seg = 7'h4F;
            4'h4: hex_to_seg = 7'h66;
            4'h5: hex_to_seg = 7'h6D;
            4'h6: hex_to_seg = 7'h7D;
            4'h7: hex_to_seg = 7'h07;
            4'h8: hex_to_seg = 7'h7F;
            4'h9: hex_to_seg = 7'h6F;
            4'hA: hex_to_seg = 7'h77;
            4'hB: hex_to_seg = 7'h7C;
            4'hC: hex_to_seg = 7'h39;
            4'hD: hex_to_seg = 7'h5E;
            4'hE: hex_to_seg = 7'h79;
            default: hex_to_seg = 7'h71;
        endcase
    endfunction

endpackage

// File: rtl/seg_shift595.sv
// seg_shift595: 16-bit MSB-first serializer with shift-clock divider and storage strobe
module seg_shift595
    import seg_led_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [15:0] word,
    output logic        done,
    output logic        clk,
    output logic        dat,
    output logic        str
);

    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    ser_state_t  state, state_n;
    logic [DW-1:0] div, div_n;
    logic        hi, hi_n;
    logic [3:0]  bitn, bitn_n;
    logic [15:0] sreg, sreg_n;
    logic        div_end;

    // next state: each bit is CLK_DIV low then CLK_DIV high, then CLK_DIV cycles of strobe
    always_comb begin
        state_n = state;
        div_n   = div;
        hi_n    = hi;
        bitn_n  = bitn;
        sreg_n  = sreg;
        div_end = div == DW'(CLK_DIV - 1);
        done    = state == SER_LATCH && div_end;
        case (state)
            SER_IDLE: if (start) begin
                state_n = SER_SHIFT;
                div_n   = '0;
                hi_n    = 1'b0;
                bitn_n  = '0;
                sreg_n  = word;
            end
            SER_SHIFT: begin
                div_n = div_end ? '0 : div + 1'b1;
                if (div_end) begin
                    hi_n = !hi;
                    if (hi) begin
                        sreg_n  = {sreg[14:0], 1'b0};
                        bitn_n  = bitn + 1'b1;
                        state_n = bitn == 4'd15 ? SER_LATCH : SER_SHIFT;
                    end
                end
            end
            SER_LATCH: begin
                div_n   = div_end ? '0 : div + 1'b1;
                state_n = div_end ? SER_IDLE : SER_LATCH;
            end
            default: state_n = SER_IDLE;
        endcase
    end

    // state and glitch-free registered pin outputs; reset drops all pins at once
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= SER_IDLE;
            div   <= '0;
            hi    <= 1'b0;
            bitn  <= '0;
            sreg  <= '0;
            clk   <= 1'b0;
            dat   <= 1'b0;
            str   <= 1'b0;
        end else begin
            state <= state_n;
            div   <= div_n;
            hi    <= hi_n;
            bitn  <= bitn_n;
            sreg  <= sreg_n;
            clk   <= state_n == SER_SHIFT && hi_n;
            dat   <= state_n == SER_SHIFT && sreg_n[15];
            str   <= state_n == SER_LATCH;
        end
    end

endmodule

// File: rtl/seg_led_hex595_n.sv
// seg_led_hex595_n: multiplexed hex display over chained 74HC595s, frame-synchronous updates
// Define SEG_LED_LZB_EN to enable leading-zero blanking on the shadowed value.
module seg_led_hex595_n
    import seg_led_pkg::*;
#(
    parameter int DIGITS  = 8,
    parameter int CLK_DIV = 4,
    parameter int HOLD    = 1000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  load,
    output logic                  clk,
    output logic                  dat,
    output logic                  str,
    output logic                  frame_done,
    output logic                  pending
);

    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;

    state_t              state, state_n;
    logic [IW-1:0]       idx, idx_n;
    logic [HW-1:0]       hcnt, hcnt_n;
    logic [4*DIGITS-1:0] sh_value, st_value, src_value;
    logic [DIGITS-1:0]   sh_dp, st_dp, src_dp, sh_blank, st_blank, src_blank;
    logic                start, done, frame_start, last, use_st, lead_zero;
    logic [6:0]          seg;
    logic [7:0]          seg_byte;
    logic [SEL_W-1:0]    sel;
    logic [15:0]         word;

    // digit sequencing: launch a word, wait for its latch, hold, advance digit
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        hcnt_n      = hcnt;
        last        = idx == IW'(DIGITS - 1);
        start       = state == ST_IDLE || (state == ST_HOLD && hcnt == HW'(HOLD - 1));
        frame_start = start && idx == '0;
        case (state)
            ST_IDLE:  state_n = ST_SHIFT;
            ST_SHIFT: if (done) begin
                state_n = ST_HOLD;
                hcnt_n  = '0;
                idx_n   = last ? '0 : idx + 1'b1;
            end
            ST_HOLD: begin
                hcnt_n  = hcnt + 1'b1;
                state_n = start ? ST_SHIFT : ST_HOLD;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // word encoding; at a frame start the staged data is used directly since the shadow updates on that same edge
    always_comb begin
        use_st    = frame_start && pending;
        src_value = use_st ? st_value : sh_value;
        src_dp    = use_st ? st_dp : sh_dp;
        src_blank = use_st ? st_blank : sh_blank;
        seg       = hex_to_seg(src_value[{idx, 2'b00} +: 4]);
`ifdef SEG_LED_LZB_EN
        lead_zero = idx != '0 && (src_value >> {idx, 2'b00}) == '0;
`else
        lead_zero = 1'b0;
`endif
        seg_byte  = src_blank[idx] ? SEG_BLANK : ~{src_dp[idx], lead_zero ? 7'd0 : seg};
        sel       = SEL_W'(1) << idx;
        word      = {seg_byte, sel};
    end

    // sequencer registers and end-of-frame pulse
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            hcnt       <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            hcnt       <= hcnt_n;
            frame_done <= done && last;
        end
    end

    // staging captures every load; shadow takes staging only at a frame start so frames never mix
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            st_value <= '0;
            st_dp    <= '0;
            st_blank <= '1;
            sh_value <= '0;
            sh_dp    <= '0;
            sh_blank <= '1;
            pending  <= 1'b0;
        end else begin
            pending <= load || (pending && !frame_start);
            if (load) begin
                st_value <= value;
                st_dp    <= dp;
                st_blank <= blank;
            end
            if (use_st) begin
                sh_value <= st_value;
                sh_dp    <= st_dp;
                sh_blank <= st_blank;
            end
        end
    end

    seg_shift595 #(.CLK_DIV(CLK_DIV)) u_shift (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .start    (start),
        .word     (word),
        .done     (done),
        .clk      (clk),
        .dat      (dat),
        .str      (str)
    );

endmodule

// File: tb/tb_seg_led_hex595_n.sv
// tb_seg_led_hex595_n: random loads checked every cycle against a timeline model of the 595 link
module tb_seg_led_hex595_n;

    localparam int DIGITS = 4;
    localparam int CD     = 1;
    localparam int HOLD   = 4;
    localparam int P      = 32 * CD + CD + HOLD;
    localparam int F      = DIGITS * P;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;
    logic        clk, dat, str, frame_done, pending;

    seg_led_hex595_n #(.DIGITS(DIGITS), .CLK_DIV(CD), .HOLD(HOLD)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .value     (value),
        .dp        (dp),
        .blank     (blank),
        .load      (load),
        .clk       (clk),
        .dat       (dat),
        .str       (str),
        .frame_done(frame_done),
        .pending   (pending)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail = 0;
    int e = 0;
    int o = -1;
    int d = 0;
    int str_rises = 0;
    int fd_count = 0;

    logic [15:0] m_value, st_value, cur, sh;
    logic [3:0]  m_dp, m_blank, st_dp, st_blank;
    logic        m_pend;
    logic        ex_clk, ex_dat, ex_str, ex_fd;
    logic [15:0] words[$];
    logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // word the display must carry for digit di, from the model's shadow
    function automatic logic [15:0] exp_word(input int di);
        logic [6:0] s;
        logic [7:0] b;
        s = seg_tab[m_value[4*di +: 4]];
`ifdef SEG_LED_LZB_EN
        if (di != 0 && (m_value >> (4 * di)) == 16'd0) s = 7'd0;
`endif
        b = m_blank[di] ? 8'hFF : ~{m_dp[di], s};
        return {b, 8'(1 << di)};
    endfunction

    // receiver side of the link: what a real 595 chain would shift and latch
    always @(posedge clk) sh = {sh[14:0], dat};
    always @(posedge str) begin
        str_rises++;
        words.push_back(sh);
    end

    // timeline model: digit k starts at edge 1+k*P after reset release
    always @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            e = 0; o = -1;
            m_value = '0; m_dp = '0; m_blank = '1;
            st_value = '0; st_dp = '0; st_blank = '1;
            m_pend = 1'b0;
            {ex_clk, ex_dat, ex_str, ex_fd} = '0;
        end else begin
            e++;
            o = (e - 1) % P;
            d = ((e - 1) / P) % DIGITS;
            if (o == 0 && d == 0) begin
                if (m_pend) {m_value, m_dp, m_blank} = {st_value, st_dp, st_blank};
                m_pend = 1'b0;
            end
            if (load) begin
                st_value = value; st_dp = dp; st_blank = blank;
                m_pend = 1'b1;
            end
            if (o == 0) cur = exp_word(d);
            ex_clk = o < 32 * CD && (o % (2 * CD)) >= CD;
            ex_dat = (o < 32 * CD) ? cur[15 - o / (2 * CD)] : 1'b0;
            ex_str = o >= 32 * CD && o < 33 * CD;
            ex_fd  = o == 33 * CD && d == DIGITS - 1;
        end
        #1;
        check("clk", clk, ex_clk);
        check("dat", dat, ex_dat);
        check("str", str, ex_str);
        check("frame_done", frame_done, ex_fd);
        check("pending", pending, m_pend);
        if (sys_rst_n && o == 32 * CD) check("latched_word", sh, cur);
        if (frame_done) fd_count++;
    end

    task automatic wait_e(input int n);
        while (e < n) @(negedge sys_clk);
    endtask

    task automatic pulse(input logic [15:0] v, input logic [3:0] p, input logic [3:0] b);
        value = v; dp = p; blank = b; load = 1'b1;
        @(negedge sys_clk);
        load = 1'b0;
    endtask

    task automatic check_word(input string name, input int i, input logic [15:0] exp);
        check(name, (i < words.size()) ? 32'(words[i]) : 32'hDEAD_0000, 32'(exp));
    endtask

    initial begin
        int n_words, n_str;
        repeat (3) @(negedge sys_clk);
        check("rst_outputs", {clk, dat, str, frame_done, pending}, 0);
        sys_rst_n = 1'b1;
        wait_e(F);
        check("fd_frame0", fd_count, 1);
        check("words_frame0", words.size(), 4);
        check_word("w0_reset", 0, 16'hFF01);
        check_word("w1_reset", 1, 16'hFF02);
        check_word("w3_reset", 3, 16'hFF08);
        wait_e(F + 20);
        pulse(16'h12AF, 4'h0, 4'h0);
        check("pend_set", pending, 1);
        wait_e(2 * F);
        check("pend_held", pending, 1);
        wait_e(2 * F + 1);
        check("pend_clear", pending, 0);
        wait_e(3 * F);
        check_word("w7_old", 7, 16'hFF08);
        check_word("w8_F", 8, 16'h8E01);
        check_word("w9_A", 9, 16'h8802);
        check_word("w10_2", 10, 16'hA404);
        check_word("w11_1", 11, 16'hF908);
        wait_e(3 * F + 10);
        pulse(16'h5555, 4'h0, 4'h0);
        wait_e(3 * F + 60);
        pulse(16'h0BAD, 4'h0, 4'h0);
        wait_e(5 * F);
        pulse(16'h4321, 4'h0, 4'h0);
        check("pend_coincident", pending, 1);
        wait_e(7 * F);
        check_word("w16_double", 16, 16'hA101);
        check_word("w20_coinc_old", 20, 16'hA101);
        check_word("w24_coinc_new", 24, 16'hF901);
        wait_e(7 * F + 10);
        pulse(16'h0030, 4'h0, 4'h0);
        wait_e(8 * F + 10);
        pulse(16'h0030, 4'b1000, 4'h0);
        wait_e(10 * F);
        check_word("w32_lz0", 32, 16'hC001);
        check_word("w33_lz3", 33, 16'hB002);
`ifdef SEG_LED_LZB_EN
        check_word("w34_lz", 34, 16'hFF04);
        check_word("w35_lz", 35, 16'hFF08);
        check_word("w39_lzdp", 39, 16'h7F08);
`else
        check_word("w34_nolz", 34, 16'hC004);
        check_word("w35_nolz", 35, 16'hC008);
        check_word("w39_dp", 39, 16'h4008);
`endif
        wait_e(10 * F + 10);
        pulse(16'h1234, 4'h0, 4'b0010);
        wait_e(12 * F);
        check_word("w44_4", 44, 16'h9901);
        check_word("w45_blank", 45, 16'hFF02);
        for (int i = 0; i < 15; i++) begin
            repeat ($urandom_range(1, 120)) @(negedge sys_clk);
            pulse(16'($urandom), 4'($urandom),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
        end
        wait_e(e + 2 * F);
        while ((e - 1) % P != 14) @(negedge sys_clk);
        n_words = words.size();
        n_str = str_rises;
        sys_rst_n = 1'b0;
        #1;
        check("midrst_outputs", {clk, dat, str, frame_done, pending}, 0);
        repeat (3) @(negedge sys_clk);
        check("midrst_no_str", str_rises, n_str);
        sys_rst_n = 1'b1;
        wait_e(P);
        check("midrst_words", words.size(), n_words + 1);
        check_word("midrst_restart", n_words, 16'hFF01);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
